// File: rtl/program_loader.sv
// Host-side program loader: streams address/data byte pairs onto the CPU bus while
// holding the CPU in reset, then releases it once every RAM location is written.
module program_loader #(
  parameter int unsigned RAM_BYTES   = 16,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] bus_data,
  output logic       bus_drive,
  output logic       sel_addr,
  output logic       cpu_rst_n,
  output logic       busy,
  output logic       done
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [3:0] AddrLast = 4'(RAM_BYTES - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StWait = 3'd1;
  localparam logic [2:0] StAddr = 3'd2;
  localparam logic [2:0] StData = 3'd3;
  localparam logic [2:0] StGap  = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [3:0]       addr_q, addr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [7:0]       data_q, data_d;
  logic             rstn_q, rstn_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    data_d  = data_q;
    rstn_d  = rstn_q;
    // abort wins over every other event; the CPU stays in reset
    if (state_q != StIdle && abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StWait;
            addr_d  = 4'd0;
            rstn_d  = 1'b0;
          end
        end
        StWait: begin
          if (in_valid) begin
            data_d  = in_data;
            state_d = StAddr;
            hold_d  = '0;
          end
        end
        StAddr: begin
          if (hold_q == HoldLast) begin
            state_d = StData;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        StData: begin
          if (hold_q == HoldLast) begin
            state_d = StGap;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        StGap: begin
          if (addr_q == AddrLast) begin
            state_d = StDone;
            rstn_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 4'd1;
            state_d = StWait;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= 4'd0;
      hold_q  <= '0;
      data_q  <= 8'h00;
      rstn_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      rstn_q  <= rstn_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StWait);
    sel_addr  = (state_q == StAddr);
    bus_drive = (state_q == StAddr) || (state_q == StData);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    cpu_rst_n = rstn_q;
    bus_data  = 8'h00;
    if (state_q == StAddr) begin
      bus_data = {4'b0000, addr_q};
    end else if (state_q == StData) begin
      bus_data = data_q;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (default and 4-byte/1-hold) checked every cycle
// against a phase-counting reference model, plus literal timing expectations.
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_v, abort_v, valid_v;
  logic [7:0] data_v;
  int         sel;
  bit         chk_en;
  int         n_chk, n_fail;

  logic       i_start [2];
  logic       i_abort [2];
  logic       i_valid [2];
  logic [7:0] i_data  [2];
  logic       o_ready [2];
  logic       o_drive [2];
  logic       o_sel   [2];
  logic       o_rstn  [2];
  logic       o_busy  [2];
  logic       o_done  [2];
  logic [7:0] o_bus   [2];

  assign i_start[0] = (sel == 0) & start_v;
  assign i_start[1] = (sel == 1) & start_v;
  assign i_abort[0] = (sel == 0) & abort_v;
  assign i_abort[1] = (sel == 1) & abort_v;
  assign i_valid[0] = (sel == 0) & valid_v;
  assign i_valid[1] = (sel == 1) & valid_v;
  assign i_data[0]  = (sel == 0) ? data_v : 8'h00;
  assign i_data[1]  = (sel == 1) ? data_v : 8'h00;

  program_loader #(.RAM_BYTES(16), .HOLD_CYCLES(2)) u_big (
    .clk(clk), .rst(rst), .start(i_start[0]), .abort(i_abort[0]),
    .in_data(i_data[0]), .in_valid(i_valid[0]), .in_ready(o_ready[0]),
    .bus_data(o_bus[0]), .bus_drive(o_drive[0]), .sel_addr(o_sel[0]),
    .cpu_rst_n(o_rstn[0]), .busy(o_busy[0]), .done(o_done[0])
  );

  program_loader #(.RAM_BYTES(4), .HOLD_CYCLES(1)) u_small (
    .clk(clk), .rst(rst), .start(i_start[1]), .abort(i_abort[1]),
    .in_data(i_data[1]), .in_valid(i_valid[1]), .in_ready(o_ready[1]),
    .bus_data(o_bus[1]), .bus_drive(o_drive[1]), .sel_addr(o_sel[1]),
    .cpu_rst_n(o_rstn[1]), .busy(o_busy[1]), .done(o_done[1])
  );

  // Model: mode 0 idle, 1 loading, 2 done pulse. While loading, t counts cycles since the
  // current byte was accepted (0 = waiting for a byte).
  typedef struct {
    int         mode;
    int         k;
    int         t;
    bit         rstn;
    logic [7:0] data;
  } mdl_t;

  mdl_t m [2];
  int   nb [2] = '{16, 4};
  int   hc [2] = '{2, 1};

  function automatic mdl_t step(mdl_t s, int n, int h, logic r, logic st, logic ab,
                                logic v, logic [7:0] d);
    mdl_t x = s;
    if (r) begin
      x.mode = 0; x.k = 0; x.t = 0; x.rstn = 1'b1; x.data = 8'h00;
    end else if (s.mode == 0) begin
      if (st) begin
        x.mode = 1; x.k = 0; x.t = 0; x.rstn = 1'b0;
      end
    end else if (ab) begin
      x.mode = 0;
    end else if (s.mode == 2) begin
      x.mode = 0;
    end else if (s.t == 0) begin
      if (v) begin
        x.data = d; x.t = 1;
      end
    end else if (s.t == 2 * h + 1) begin
      if (s.k == n - 1) begin
        x.mode = 2; x.rstn = 1'b1;
      end else begin
        x.k = s.k + 1; x.t = 0;
      end
    end else begin
      x.t = s.t + 1;
    end
    return x;
  endfunction

  task automatic chk(input int u, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL u%0d.%s: got %0d expected %0d at %0t", u, nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m[i] = step(m[i], nb[i], hc[i], rst, i_start[i], i_abort[i], i_valid[i], i_data[i]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        bit         er, ed, es;
        logic [7:0] eb;
        er = (m[i].mode == 1) && (m[i].t == 0);
        ed = (m[i].mode == 1) && (m[i].t >= 1) && (m[i].t <= 2 * hc[i]);
        es = (m[i].mode == 1) && (m[i].t >= 1) && (m[i].t <= hc[i]);
        eb = es ? 8'(m[i].k) : (ed ? m[i].data : 8'h00);
        chk(i, "in_ready", 32'(o_ready[i]), 32'(er));
        chk(i, "bus_drive", 32'(o_drive[i]), 32'(ed));
        chk(i, "sel_addr", 32'(o_sel[i]), 32'(es));
        chk(i, "bus_data", 32'(o_bus[i]), 32'(eb));
        chk(i, "busy", 32'(o_busy[i]), 32'(m[i].mode != 0));
        chk(i, "done", 32'(o_done[i]), 32'(m[i].mode == 2));
        chk(i, "cpu_rst_n", 32'(o_rstn[i]), 32'(m[i].rstn));
      end
    end
  end

  // One load on instance `sel`. Cycle 0 is the cycle start is held high.
  task automatic load(input int base, input int stp, input int stall_at, input bit restarts,
                      input int abort_at, input int rst_at, input bit rnd, input int exp_done);
    int idx = 0, got = -1, stall_n = 0, lowcnt = 0;
    bit aborted = 0, rsted = 0, ended = 0;
    for (int c = 0; c < 600 && !ended; c++) begin
      @(negedge clk);
      if (aborted || rsted) begin
        chk(sel, "stop_busy", 32'(o_busy[sel]), 32'd0);
        chk(sel, "stop_drive", 32'(o_drive[sel]), 32'd0);
        chk(sel, "stop_rstn", 32'(o_rstn[sel]), rsted ? 32'd1 : 32'd0);
        ended = 1;
      end else if (o_done[sel]) begin
        got = c;
        ended = 1;
      end else begin
        if (c > 0 && !o_rstn[sel]) lowcnt++;
        start_v = (c == 0) || (restarts && (c == 10 || c == 40)) ||
                  (rnd && $urandom_range(0, 29) == 0);
        abort_v = 1'b0;
        rst     = 1'b0;
        valid_v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (idx == stall_at && o_ready[sel] && stall_n < 5) begin
          valid_v = 1'b0;
          stall_n++;
        end
        data_v = rnd ? 8'($urandom) : 8'(base + idx * stp);
        if (idx == abort_at + 1 && o_drive[sel] && !o_sel[sel]) begin
          abort_v = 1'b1; aborted = 1;
        end
        if (rnd && o_busy[sel] && $urandom_range(0, 199) == 0) begin
          abort_v = 1'b1; aborted = 1;
        end
        if (idx == rst_at + 1 && o_sel[sel]) begin
          rst = 1'b1; rsted = 1;
        end
        if (o_ready[sel] && valid_v && !abort_v && !rst) idx++;
      end
    end
    start_v = 1'b0; valid_v = 1'b0; abort_v = 1'b0; rst = 1'b0;
    if (exp_done >= 0) begin
      chk(sel, "done_cycle", 32'(got), 32'(exp_done));
      chk(sel, "rstn_low_cycles", 32'(lowcnt), 32'(exp_done - 1));
      chk(sel, "done_rstn", 32'(o_rstn[sel]), 32'd1);
    end else if (!aborted && !rsted) begin
      chk(sel, "load_completed", 32'(got > 0), 32'd1);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 0; sel = 0;
    rst = 1'b1; start_v = 1'b0; abort_v = 1'b0; valid_v = 1'b0; data_v = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1;
    for (int i = 0; i < 2; i++) begin
      chk(i, "rst_busy", 32'(o_busy[i]), 32'd0);
      chk(i, "rst_rstn", 32'(o_rstn[i]), 32'd1);
      chk(i, "rst_bus", 32'(o_bus[i]), 32'd0);
      chk(i, "rst_drive", 32'(o_drive[i]), 32'd0);
      chk(i, "rst_ready", 32'(o_ready[i]), 32'd0);
    end
    repeat (2) @(negedge clk);

    load(8'hA0, 1, 99, 0, 99, 99, 0, 97);
    repeat (3) @(negedge clk);
    load(8'hA0, 1, 3, 0, 99, 99, 0, 102);
    repeat (3) @(negedge clk);
    load(8'hA0, 1, 99, 0, 7, 99, 0, -1);
    repeat (3) @(negedge clk);
    chk(0, "abort_rstn_held", 32'(o_rstn[0]), 32'd0);
    load(8'hA0, 1, 99, 0, 99, 99, 0, 97);
    repeat (3) @(negedge clk);
    load(8'hA0, 1, 99, 1, 99, 99, 0, 97);
    repeat (3) @(negedge clk);
    load(8'hA0, 1, 99, 0, 99, 4, 0, -1);
    valid_v = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk(0, "nostart_ready", 32'(o_ready[0]), 32'd0);
    end
    valid_v = 1'b0;
    repeat (2) @(negedge clk);

    sel = 1;
    load(8'h11, 8'h11, 99, 0, 99, 99, 0, 17);
    repeat (3) @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      sel = r % 2;
      load(0, 0, 99, 0, 99, 99, 1, -1);
      repeat (3) @(negedge clk);
    end
    sel = 0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Host-side program loader for the 8-bit CPU. It accepts a stream of program bytes over a valid/ready handshake and holds the CPU in reset while it works. For each of the RAM_BYTES locations, it drives an address byte and then a data byte onto the CPU's external bus input (ui_in) with its drive strobe (uio_in[0]). When every location is written, it releases the CPU to run.

## Interface

Parameters:
- RAM_BYTES, 16: number of RAM locations written per load; legal range 2..16.
- HOLD_CYCLES, 2: cycles each byte is held on the bus; must be ≥1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a load; sampled only in IDLE.
- abort  in  1  cancel the load in progress; sampled in every non-IDLE state.
- in_data  in  8  program byte from the host.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- bus_data  out  8  byte driven toward CPU ui_in.
- bus_drive  out  1  strobe, connects to CPU uio_in[0]; bus_data is meaningful only while this is high.
- sel_addr  out  1  1 = address phase, 0 = data phase; qualifies bus_drive.
- cpu_rst_n  out  1  active-low reset to the CPU (rst_n).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the load completes.

## Operation

- State machine is Moore: all outputs decode from the registered state, addr counter and data register.
- States: IDLE, WAIT, ADDR, DATA, GAP, DONE.
- IDLE:
  - Outputs: in_ready=0, bus_drive=0, busy=0.
  - start=1 → WAIT, addr counter=0, cpu_rst_n=0.
- WAIT:
  - Outputs: in_ready=1.
  - in_valid & in_ready → latch in_data into data_reg, go to ADDR.
  - Otherwise stay in WAIT, with no timeout.
- ADDR:
  - Outputs: bus_drive=1, sel_addr=1, bus_data={4'b0, addr}.
  - Held HOLD_CYCLES cycles, then DATA.
- DATA:
  - Outputs: bus_drive=1, sel_addr=0, bus_data=data_reg.
  - Held HOLD_CYCLES cycles, then GAP.
- GAP:
  - Outputs: bus_drive=0; one cycle, so the bus floats between bytes.
  - If addr==RAM_BYTES-1 → DONE; else addr+1 → WAIT.
- DONE:
  - Outputs: done=1, cpu_rst_n=1; one cycle, then IDLE.
- Counters:
  - addr counter is 4 bits and never wraps within a load.
  - Hold counter is $clog2(HOLD_CYCLES+1) bits and clears on every ADDR/DATA entry.
- Output rules by state:
  - in_ready is high only in WAIT.
  - bus_drive is high only in ADDR/DATA.
  - bus_data is 8'h00 whenever bus_drive=0.
- cpu_rst_n is a register:
  - Cleared on start acceptance.
  - Set on DONE entry.
  - Otherwise holds its value.
- abort=1 in any non-IDLE state:
  - Go to IDLE next edge; bus_drive=0 from that edge.
  - cpu_rst_n stays 0; the CPU remains in reset until a later load completes.
  - done does not pulse.
  - abort outranks in_valid and hold-counter expiry in the same cycle.
- start while busy is ignored.
- in_valid outside WAIT is ignored; no byte is consumed.

## Timing

- Reset values: state=IDLE, in_ready=0, bus_data=8'h00, bus_drive=0, sel_addr=0, cpu_rst_n=1, busy=0, done=0. Addr, hold and data registers are cleared.
- rst mid-load behaves like abort, except cpu_rst_n returns to 1.
- start sampled at edge N → busy=1, cpu_rst_n=0 from cycle N+1.
- Handshake completes in the cycle in_valid=in_ready=1. bus_drive rises the following cycle.
- Per-byte cost with in_valid held high: 2·HOLD_CYCLES+2 cycles, which is 6 with defaults.
- Full load with defaults:
  - start at cycle 0.
  - Byte k occupies cycles 1+6k..6+6k.
  - done=1 and cpu_rst_n=1 at cycle 97.
  - IDLE at cycle 98.
- in_valid stalls extend WAIT only; ADDR/DATA/GAP durations are fixed.

## Test plan

- Default params, start pulse, 16 bytes 8'hA0..8'hAF with in_valid held high:
  - Address phases carry 0..15, each sel_addr=1 for 2 cycles.
  - Data phases carry A0..AF, each for 2 cycles.
  - done pulses at cycle 97; cpu_rst_n is 0 from cycle 1 to cycle 96, 1 at 97.
- Same stimulus, but in_valid drops for 5 cycles before byte 3:
  - in_ready stays high for 6 cycles in WAIT.
  - bus_drive stays 0 during the stall.
  - done is delayed by exactly 5 cycles, to cycle 102.
- abort asserted during the DATA phase of byte 7:
  - Next cycle: IDLE, bus_drive=0, busy=0.
  - done never pulses; cpu_rst_n stays 0.
  - A new start and full load then gives done with cpu_rst_n=1.
- start re-pulsed at cycles 10 and 40 during a load: no effect; byte sequence and done timing are identical to the first scenario.
- rst asserted for one cycle during byte 4's ADDR phase:
  - All outputs take their reset values next cycle, including cpu_rst_n=1.
  - in_valid with no start: in_ready stays 0.
- RAM_BYTES=4, HOLD_CYCLES=1, bytes 11,22,33,44:
  - 4-cycle per-byte rhythm.
  - Address phases 0..3.
  - done at cycle 17.
